// File: rtl/video_capture.sv
// Video input receiver: recovers x/y from active-low syncs, measures timing,
// declares lock and captures one visible line. Optional input sync: VCAP_SYNC_EN.
module video_capture #(
    parameter int H_DISP  = 640,
    parameter int H_PULSE = 96,
    parameter int H_BACK  = 48,
    parameter int V_DISP  = 480,
    parameter int V_PULSE = 2,
    parameter int V_BACK  = 33
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              red,
    input  logic              green,
    input  logic              blue,
    input  logic              capture_en,
    input  logic [9:0]        capture_line,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic              is_visible,
    output logic              frame_start,
    output logic              line_done,
    output logic [H_DISP-1:0] line_r,
    output logic [H_DISP-1:0] line_g,
    output logic [H_DISP-1:0] line_b,
    output logic [9:0]        h_total,
    output logic [9:0]        v_total,
    output logic              locked
);
    localparam logic [9:0]  H_START = 10'(H_PULSE + H_BACK);
    localparam logic [9:0]  H_END   = 10'(H_PULSE + H_BACK + H_DISP);
    localparam logic [9:0]  X_LAST  = 10'(H_DISP - 1);
    // line counter runs one ahead of l so that "before first hsync" is 0
    localparam logic [10:0] V_START = 11'(V_PULSE + V_BACK + 1);
    localparam logic [10:0] V_END   = 11'(V_PULSE + V_BACK + V_DISP + 1);
    localparam logic [4:0]  IDLE    = 5'b11000;

    logic [4:0]  pins, s_in, s, s_prev;
    logic        hs_fall, vs_fall, p_sat, vis_d, cap_hit;
    logic        cap_en_q, done_q, h_stable, have_first;
    logic [9:0]  p_q, p_d, x_d, y_d, h_meas, v_meas;
    logic [9:0]  cap_line_q, first_h, prev_h;
    logic [10:0] lc_q, lc_d;

    assign pins = {hsync, vsync, red, green, blue};

`ifdef VCAP_SYNC_EN
    logic [4:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    assign s_in = sync2;
`else
    assign s_in = pins;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s      <= IDLE;
            s_prev <= IDLE;
        end else begin
            s      <= s_in;
            s_prev <= s;
        end
    end

    assign hs_fall = s_prev[4] & ~s[4];
    assign vs_fall = s_prev[3] & ~s[3];

    always_comb begin
        p_d = p_q;
        if (hs_fall)
            p_d = '0;
        else if (p_q != 10'd1023)
            p_d = p_q + 10'd1;
        lc_d = lc_q;
        if (vs_fall)
            lc_d = {10'd0, hs_fall};
        else if (hs_fall && lc_q != 11'd1024)
            lc_d = lc_q + 11'd1;
    end

    assign p_sat   = p_d == 10'd1023;
    assign h_meas  = (p_q == 10'd1023) ? p_q : p_q + 10'd1;
    assign v_meas  = lc_q[10] ? 10'd1023 : lc_q[9:0];
    assign x_d     = p_d - H_START;
    assign y_d     = lc_d[9:0] - V_START[9:0];
    assign vis_d   = p_d >= H_START && p_d < H_END &&
                     lc_d >= V_START && lc_d < V_END && !p_sat;
    assign cap_hit = vis_d && cap_en_q && y_d == cap_line_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            p_q         <= '0;
            lc_q        <= '0;
            x           <= '0;
            y           <= '0;
            is_visible  <= 1'b0;
            frame_start <= 1'b0;
            done_q      <= 1'b0;
            line_done   <= 1'b0;
            cap_en_q    <= 1'b0;
            cap_line_q  <= '0;
        end else begin
            p_q         <= p_d;
            lc_q        <= lc_d;
            x           <= x_d;
            y           <= y_d;
            is_visible  <= vis_d;
            frame_start <= vs_fall;
            done_q      <= cap_hit && x_d == X_LAST;
            line_done   <= done_q;
            if (hs_fall) begin
                cap_en_q   <= capture_en;
                cap_line_q <= capture_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            line_r <= '0;
            line_g <= '0;
            line_b <= '0;
        end else if (cap_hit) begin
            for (int i = 0; i < H_DISP; i++) begin
                if (x_d == 10'(i)) begin
                    line_r[i] <= s[2];
                    line_g[i] <= s[1];
                    line_b[i] <= s[0];
                end
            end
        end
    end

    // vsync is handled before a coincident hsync: lock uses the old h_total
    always_ff @(posedge clk) begin
        if (!resetn) begin
            h_total    <= '0;
            v_total    <= '0;
            prev_h     <= '0;
            first_h    <= '0;
            have_first <= 1'b0;
            h_stable   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            if (vs_fall) begin
                v_total    <= v_meas;
                prev_h     <= h_total;
                h_stable   <= 1'b1;
                have_first <= 1'b0;
                locked     <= h_stable && h_total == prev_h && v_meas == v_total;
            end
            if (hs_fall) begin
                h_total <= h_meas;
                if (vs_fall || !have_first) begin
                    first_h    <= h_meas;
                    have_first <= 1'b1;
                end else if (h_meas != first_h) begin
                    h_stable <= 1'b0;
                end
            end
            if (p_sat)
                locked <= 1'b0;
        end
    end
endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a scaled 28-clock x 12-line timing.
// Pins are driven sample by sample; a passive monitor counts output pulses.
`timescale 1ns/1ps
module tb_video_capture;
    localparam int HD = 16, HP = 4, HB = 4;
    localparam int VD = 6, VP = 1, VB = 2;
    localparam int LLEN = 28, NLINES = 12, NONE = -100;
`ifdef VCAP_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0, resetn = 1'b0;
    logic          hsync = 1'b1, vsync = 1'b1;
    logic          red = 1'b0, green = 1'b0, blue = 1'b0;
    logic          capture_en = 1'b0;
    logic [9:0]    capture_line = '0;
    logic [9:0]    x, y, h_total, v_total;
    logic          is_visible, frame_start, line_done, locked;
    logic [HD-1:0] line_r, line_g, line_b;

    int   errs = 0, checks = 0;
    int   fs_cnt = 0, ld_cnt = 0, ld_bad = 0;
    bit   vs_simul = 1'b0;
    logic pv_vis = 1'b0;
    logic [9:0] pv_x = '0;

    always #5 clk = ~clk;

    video_capture #(
        .H_DISP(HD), .H_PULSE(HP), .H_BACK(HB),
        .V_DISP(VD), .V_PULSE(VP), .V_BACK(VB)
    ) dut (
        .clk(clk), .resetn(resetn),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .capture_en(capture_en), .capture_line(capture_line),
        .x(x), .y(y), .is_visible(is_visible),
        .frame_start(frame_start), .line_done(line_done),
        .line_r(line_r), .line_g(line_g), .line_b(line_b),
        .h_total(h_total), .v_total(v_total), .locked(locked)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_start === 1'b1)
            fs_cnt++;
        if (line_done === 1'b1) begin
            ld_cnt++;
            if (!(pv_vis === 1'b1 && pv_x == 10'(HD - 1)))
                ld_bad++;
        end
        pv_vis = is_visible;
        pv_x   = x;
    end

    task automatic drive_line(input int ln, input int len, input bit hs_on,
                              input int mode, input int chg_c,
                              input int rst_c, input bit chk);
        int xi;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (chk && c == 9 + LAT)
                check("vis_pre", 64'(is_visible), 64'd0);
            if (chk && c == 10 + LAT) begin
                check("vis_rise", 64'(is_visible), 64'd1);
                check("x_first", 64'(x), 64'd0);
                check("y_line", 64'(y), 64'(ln - 5));
            end
            if (c == rst_c + 1) begin
                check("rst_x", 64'(x), 64'd0);
                check("rst_vis", 64'(is_visible), 64'd0);
                check("rst_lock", 64'(locked), 64'd0);
                check("rst_htot", 64'(h_total), 64'd0);
                check("rst_vtot", 64'(v_total), 64'd0);
                check("rst_line_r", 64'(line_r), 64'd0);
                resetn = 1'b1;
            end
            if (c == rst_c)
                resetn = 1'b0;
            if (c == chg_c)
                capture_line = 10'd5;
            xi    = c - 10;
            hsync = !(hs_on && c >= 2 && c < 6);
            if (vs_simul)
                vsync = !((ln == 2 && c >= 2) || (ln == 3 && c < 2));
            else
                vsync = (ln != 2);
            red   = 1'b0;
            green = 1'b0;
            blue  = 1'b0;
            if (xi >= 0 && xi < HD) begin
                case (mode)
                    1: red = xi[0];
                    2: begin
                        red   = (ln == 10) ? !xi[0] : 1'b1;
                        green = (xi == 3);
                        blue  = (xi == 12);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic lines(input int first, input int last, input int mode);
        for (int ln = first; ln <= last; ln++)
            drive_line(ln, LLEN, 1'b1, mode, NONE, NONE, 1'b0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("reset_x", 64'(x), 64'd0);
        check("reset_y", 64'(y), 64'd0);
        check("reset_vis", 64'(is_visible), 64'd0);
        check("reset_fs", 64'(frame_start), 64'd0);
        check("reset_ld", 64'(line_done), 64'd0);
        check("reset_lock", 64'(locked), 64'd0);
        check("reset_htot", 64'(h_total), 64'd0);
        check("reset_vtot", 64'(v_total), 64'd0);
        check("reset_lines", 64'(line_r | line_g | line_b), 64'd0);
        resetn = 1'b1;

        lines(0, 4, 0);
        drive_line(5, LLEN, 1'b1, 0, NONE, NONE, 1'b1);
        lines(6, 11, 0);
        check("f1_htot", 64'(h_total), 64'd28);
        check("f1_vtot", 64'(v_total), 64'd2);
        check("f1_lock", 64'(locked), 64'd0);

        lines(0, 7, 0);
        drive_line(8, LLEN, 1'b1, 0, NONE, NONE, 1'b1);
        lines(9, 11, 0);
        check("f2_vtot", 64'(v_total), 64'd12);
        check("f2_lock", 64'(locked), 64'd0);

        capture_en   = 1'b1;
        capture_line = 10'd0;
        lines(0, 11, 1);
        check("f3_lock", 64'(locked), 64'd1);
        check("f3_vtot", 64'(v_total), 64'd12);
        check("f3_fs", 64'(fs_cnt), 64'd3);
        check("f3_ld", 64'(ld_cnt), 64'd1);
        check("f3_line_r", 64'(line_r), 64'h0000_0000_0000_aaaa);
        check("f3_line_g", 64'(line_g), 64'd0);
        check("f3_line_b", 64'(line_b), 64'd0);

        vs_simul = 1'b1;
        lines(0, 4, 2);
        drive_line(5, LLEN, 1'b1, 2, 17, NONE, 1'b0);
        lines(6, 6, 2);
        check("f4_ld0", 64'(ld_cnt), 64'd2);
        check("f4_line0_r", 64'(line_r), 64'h0000_0000_0000_ffff);
        check("f4_line0_g", 64'(line_g), 64'h0000_0000_0000_0008);
        check("f4_line0_b", 64'(line_b), 64'h0000_0000_0000_1000);
        lines(7, 11, 2);
        capture_en = 1'b0;
        check("f4_ld5", 64'(ld_cnt), 64'd3);
        check("f4_line5_r", 64'(line_r), 64'h0000_0000_0000_5555);
        check("f4_lock", 64'(locked), 64'd1);

        lines(0, 4, 0);
        drive_line(5, LLEN, 1'b1, 0, NONE, NONE, 1'b1);
        check("f5_lock_pre", 64'(locked), 64'd1);
        drive_line(6, 1100, 1'b0, 0, NONE, NONE, 1'b0);
        check("sat_lock", 64'(locked), 64'd0);
        check("sat_vis", 64'(is_visible), 64'd0);
        lines(7, 11, 0);

        lines(0, 11, 0);
        check("f6_lock", 64'(locked), 64'd0);
        check("f6_vtot", 64'(v_total), 64'd11);
        lines(0, 11, 0);
        check("f7_lock", 64'(locked), 64'd0);
        check("f7_vtot", 64'(v_total), 64'd12);
        lines(0, 11, 0);
        check("f8_lock", 64'(locked), 64'd1);

        lines(0, 5, 0);
        drive_line(6, LLEN + 1, 1'b1, 0, NONE, NONE, 1'b0);
        lines(7, 7, 0);
        check("long_htot", 64'(h_total), 64'd29);
        lines(8, 11, 0);
        check("f9_lock", 64'(locked), 64'd1);
        lines(0, 11, 0);
        check("f10_lock", 64'(locked), 64'd0);
        check("f10_htot", 64'(h_total), 64'd28);
        lines(0, 11, 0);
        check("f11_lock", 64'(locked), 64'd1);

        lines(0, 6, 0);
        drive_line(7, LLEN, 1'b1, 0, NONE, 15, 1'b0);
        lines(8, 11, 0);
        lines(0, 11, 0);
        check("f13_vtot", 64'(v_total), 64'd6);
        check("f13_lock", 64'(locked), 64'd0);
        lines(0, 11, 0);
        check("f14_lock", 64'(locked), 64'd0);
        lines(0, 11, 0);
        check("f15_lock", 64'(locked), 64'd1);

        check("fs_total", 64'(fs_cnt), 64'd15);
        check("ld_align", 64'(ld_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
